shapool_host_link: RTL

Host-side transmitter/receiver for the shapool device serial interface. It loads one device (daisy configuration, then job parameters) by generating `data_clk`, `data_in`, `daisy_sel` and the device `reset`. It then releases the device, waits for a success or done flag, and shifts the 32-bit result nonce back out of the device's data output. It sits on the controller FPGA/MCU-bridge side, opposite the device `top`, and drives the same signals a bench would drive.

---
 rtl/shapool_host_link.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/shapool_host_link.sv
// Host-side serial link for one shapool device: shifts daisy and job words in,
// releases the device, waits for its success/done flag and reads the nonce back.
module shapool_host_link #(
  parameter int CLK_DIV     = 2,
  parameter int DAISY_BITS  = 8,
  parameter int JOB_BITS    = 360,
  parameter int RESULT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DAISY_BITS-1:0]  daisy_data,
  input  logic [JOB_BITS-1:0]    job_data,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [RESULT_BITS-1:0] result,
  output logic                   result_valid,
  output logic                   dev_reset,
  output logic                   dev_daisy_sel,
  output logic                   dev_data_clk,
  output logic                   dev_data_in,
  input  logic                   dev_data_out,
  input  logic                   dev_success,
  input  logic                   dev_done
);

  localparam int DW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BW = $clog2(JOB_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HIGH   = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_SAMPLE = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DAISY  = 3'd1,
    JOB    = 3'd2,
    RUN    = 3'd3,
    READ   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t                 state, state_nx;
  logic [DW-1:0]          div, div_nx;
  logic [BW-1:0]          bcnt, bcnt_nx;
  logic [DAISY_BITS-1:0]  daisy_sr, daisy_sr_nx;
  logic [JOB_BITS-1:0]    job_sr, job_sr_nx;
  logic [RESULT_BITS-1:0] result_sr, result_sr_nx, result_nx;
  logic                   result_valid_nx, found_nx;
  logic                   succ_meta, succ_sync, fin_meta, fin_sync;
  logic                   slot_end;
  logic                   busy_nx, done_nx, dev_reset_nx, dev_daisy_sel_nx;
  logic                   dev_data_clk_nx, dev_data_in_nx;

  assign slot_end = (div == DIV_LAST);

  // Device flags cross in through two flops each
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      succ_meta <= 1'b0;
      succ_sync <= 1'b0;
      fin_meta  <= 1'b0;
      fin_sync  <= 1'b0;
    end else begin
      succ_meta <= dev_success;
      succ_sync <= succ_meta;
      fin_meta  <= dev_done;
      fin_sync  <= fin_meta;
    end
  end

  // Next-state, datapath and next-output decode
  always_comb begin
    state_nx        = state;
    div_nx          = div;
    bcnt_nx         = bcnt;
    daisy_sr_nx     = daisy_sr;
    job_sr_nx       = job_sr;
    result_sr_nx    = result_sr;
    result_nx       = result;
    result_valid_nx = result_valid;
    found_nx        = found;
    case (state)
      IDLE: begin
        if (start) begin
          daisy_sr_nx     = daisy_data;
          job_sr_nx       = job_data;
          result_valid_nx = 1'b0;
          div_nx          = {DW{1'b0}};
          bcnt_nx         = BW'(DAISY_BITS - 1);
          state_nx        = DAISY;
        end else begin
          div_nx = {DW{1'b0}};
        end
      end
      DAISY: begin
        div_nx = slot_end ? {DW{1'b0}} : div + {{(DW-1){1'b0}}, 1'b1};
        if (slot_end) begin
          daisy_sr_nx = daisy_sr >> 1;
          if (bcnt == {BW{1'b0}}) begin
            bcnt_nx  = BW'(JOB_BITS - 1);
            state_nx = JOB;
          end else begin
            bcnt_nx = bcnt - {{(BW-1){1'b0}}, 1'b1};
          end
        end else begin
          bcnt_nx = bcnt;
        end
      end
      JOB: begin
        div_nx = slot_end ? {DW{1'b0}} : div + {{(DW-1){1'b0}}, 1'b1};
        if (slot_end) begin
          job_sr_nx = job_sr >> 1;
          if (bcnt == {BW{1'b0}}) begin
            state_nx = RUN;
          end else begin
            bcnt_nx = bcnt - {{(BW-1){1'b0}}, 1'b1};
          end
        end else begin
          bcnt_nx = bcnt;
        end
      end
      RUN: begin
        // Success takes priority over pool exhaustion
        if (succ_sync) begin
          div_nx   = {DW{1'b0}};
          bcnt_nx  = BW'(RESULT_BITS - 1);
          state_nx = READ;
        end else if (fin_sync) begin
          found_nx        = 1'b0;
          result_valid_nx = 1'b0;
          state_nx        = FINISH;
        end else begin
          div_nx = {DW{1'b0}};
        end
      end
      READ: begin
        div_nx = slot_end ? {DW{1'b0}} : div + {{(DW-1){1'b0}}, 1'b1};
        if (div == DIV_SAMPLE) begin
          result_sr_nx = {dev_data_out, result_sr[RESULT_BITS-1:1]};
        end else begin
          result_sr_nx = result_sr;
        end
        if (slot_end) begin
          if (bcnt == {BW{1'b0}}) begin
            result_nx       = result_sr;
            found_nx        = 1'b1;
            result_valid_nx = 1'b1;
            state_nx        = FINISH;
          end else begin
            bcnt_nx = bcnt - {{(BW-1){1'b0}}, 1'b1};
          end
        end else begin
          bcnt_nx = bcnt;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (abort) begin
      state_nx        = IDLE;
      div_nx          = {DW{1'b0}};
      bcnt_nx         = {BW{1'b0}};
      result_nx       = result;
      result_valid_nx = result_valid;
      found_nx        = found;
    end else begin
      bcnt_nx = bcnt_nx;
    end

    busy_nx          = (state_nx != IDLE);
    done_nx          = (state_nx == FINISH);
    dev_reset_nx     = !((state_nx == RUN) || (state_nx == READ) || (state_nx == FINISH));
    dev_daisy_sel_nx = (state_nx == DAISY);
    dev_data_clk_nx  = ((state_nx == DAISY) || (state_nx == JOB) || (state_nx == READ))
                       && (div_nx >= DIV_HIGH);
    case (state_nx)
      DAISY:   dev_data_in_nx = daisy_sr_nx[0];
      JOB:     dev_data_in_nx = job_sr_nx[0];
      default: dev_data_in_nx = 1'b0;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      div           <= {DW{1'b0}};
      bcnt          <= {BW{1'b0}};
      daisy_sr      <= {DAISY_BITS{1'b0}};
      job_sr        <= {JOB_BITS{1'b0}};
      result_sr     <= {RESULT_BITS{1'b0}};
      result        <= {RESULT_BITS{1'b0}};
      result_valid  <= 1'b0;
      found         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      dev_reset     <= 1'b1;
      dev_daisy_sel <= 1'b0;
      dev_data_clk  <= 1'b0;
      dev_data_in   <= 1'b0;
    end else begin
      state         <= state_nx;
      div           <= div_nx;
      bcnt          <= bcnt_nx;
      daisy_sr      <= daisy_sr_nx;
      job_sr        <= job_sr_nx;
      result_sr     <= result_sr_nx;
      result        <= result_nx;
      result_valid  <= result_valid_nx;
      found         <= found_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      dev_reset     <= dev_reset_nx;
      dev_daisy_sel <= dev_daisy_sel_nx;
      dev_data_clk  <= dev_data_clk_nx;
      dev_data_in   <= dev_data_in_nx;
    end
  end

endmodule
